// File: rtl/shift_add_seq_ctrl_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier controller.
package shift_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Step counter width: enough bits to count 0..WIDTH-1.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/shift_add_seq_ctrl_step.sv
// One combinational shift-add iteration: conditionally add mcand into the upper half,
// then shift right by one, keeping the carry as the new MSB.
module shift_add_step #(
  parameter int WIDTH = 4
) (
  input  logic [2*WIDTH-1:0] p,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH-1:0] p_next
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_addend
      assign addend[gi] = mcand[gi] & p[0];
    end
  endgenerate

  assign sum    = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign p_next = {sum, p[WIDTH-1:1]};

endmodule

// File: rtl/shift_add_seq_ctrl.sv
// Sequential shift-add multiplier: accepts a/b over valid/ready, runs WIDTH steps,
// then presents the 2*WIDTH-bit product over valid/ready.
module shift_add_seq_ctrl
  import shift_add_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int              CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [WIDTH-1:0]   mcand_reg, mcand_next;
  logic [2*WIDTH-1:0] p_reg, p_next, p_step;
  logic [2*WIDTH-1:0] product_reg, product_next;

  shift_add_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .p      (p_reg),
    .mcand  (mcand_reg),
    .p_next (p_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      mcand_reg   <= '0;
      p_reg       <= '0;
      product_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      mcand_reg   <= mcand_next;
      p_reg       <= p_next;
      product_reg <= product_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    mcand_next   = mcand_reg;
    p_next       = p_reg;
    product_next = product_reg;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mcand_next = a;
          p_next     = {{WIDTH{1'b0}}, b};
          cnt_next   = '0;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        busy     = 1'b1;
        p_next   = p_step;
        cnt_next = cnt_reg + CNT_W'(1);
        // Fixed latency: always WIDTH steps, product captured on the last one.
        if (cnt_reg == CNT_LAST) begin
          cnt_next     = '0;
          product_next = p_step;
          state_next   = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign product = product_reg;

endmodule

// File: tb/tb_shift_add_seq_ctrl.sv
// Self-checking bench: a timeline model (accept -> WIDTH edges -> result -> handshake)
// checked every cycle, plus directed literal expectations for WIDTH=4 and WIDTH=8 instances.
module tb_shift_add_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       iv4, ir4, ov4, ordy4, busy4;
  logic [3:0] a4, b4;
  logic [7:0] p4;
  logic       iv8, ir8, ov8, ordy8, busy8;
  logic [7:0] a8, b8;
  logic [15:0] p8;

  shift_add_seq_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(ordy4), .product(p4), .busy(busy4)
  );

  shift_add_seq_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(ordy8), .product(p8), .busy(busy8)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model state per instance (0: WIDTH=4, 1: WIDTH=8)
  int m_free[2];
  int m_left[2];
  int m_pend[2];
  int m_ov[2];
  int m_prod[2];

  int log4[$];
  int logc4[$];
  int log8_n = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  task automatic model_reset(input int k);
    m_free[k] = 1;
    m_left[k] = 0;
    m_pend[k] = 0;
    m_ov[k]   = 0;
    m_prod[k] = 0;
  endtask

  // Timeline: accept loads a*b and a countdown of w edges; result shows when it expires.
  task automatic model_step(input int k, input int w, input bit iv, input bit ordy,
                            input int av, input int bv);
    if (m_ov[k] != 0) begin
      if (ordy) begin
        m_ov[k]   = 0;
        m_free[k] = 1;
      end
    end else if (m_free[k] == 0) begin
      m_left[k]--;
      if (m_left[k] == 0) begin
        m_ov[k]   = 1;
        m_prod[k] = m_pend[k];
      end
    end else if (iv) begin
      m_free[k] = 0;
      m_left[k] = w;
      m_pend[k] = av * bv;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, 4, iv4, ordy4, int'(a4), int'(b4));
      model_step(1, 8, iv8, ordy8, int'(a8), int'(b8));
    end
  end

  always @(negedge rst_n) begin
    model_reset(0);
    model_reset(1);
  end

  always @(negedge clk) begin
    check("w4_in_ready",  ir4,   (m_free[0] != 0));
    check("w4_out_valid", ov4,   (m_ov[0] != 0));
    check("w4_busy",      busy4, (m_free[0] == 0 && m_ov[0] == 0));
    check("w4_product",   p4,    m_prod[0]);
    check("w8_in_ready",  ir8,   (m_free[1] != 0));
    check("w8_out_valid", ov8,   (m_ov[1] != 0));
    check("w8_busy",      busy8, (m_free[1] == 0 && m_ov[1] == 0));
    check("w8_product",   p8,    m_prod[1]);
    if (rst_n && ov4 && ordy4) begin
      log4.push_back(int'(p4));
      logc4.push_back(cyc);
    end
    if (rst_n && ov8 && ordy8) log8_n++;
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic op4(input int av, input int bv);
    a4 = 4'(av);
    b4 = 4'(bv);
    iv4 = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ir4) begin
        @(posedge clk); #1;
        iv4 = 1'b0;
        $display("op4 a=%0d b=%0d accepted cyc=%0d", av, bv, cyc);
        return;
      end
      @(posedge clk); #1;
    end
    iv4 = 1'b0;
    bound_fail("op4_accept");
  endtask

  task automatic op8(input int av, input int bv);
    a8 = 8'(av);
    b8 = 8'(bv);
    iv8 = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ir8) begin
        @(posedge clk); #1;
        iv8 = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    iv8 = 1'b0;
    bound_fail("op8_accept");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    rst_n = 1'b0;
    iv4 = 1'b0; a4 = '0; b4 = '0; ordy4 = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; ordy8 = 1'b1;
    model_reset(0);
    model_reset(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready4", ir4, 1);
    check("rst_out_valid4", ov4, 0);
    check("rst_busy4", busy4, 0);
    check("rst_product4", p4, 0);
    check("rst_in_ready8", ir8, 1);
    check("rst_product8", p8, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: 5*3, latency
    op4(5, 3);
    @(negedge clk);
    check("t1_in_ready_drop", ir4, 0);
    n = 0;
    while (!ov4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t1_edges_after_accept", n, 4);
    check("t1_product", p4, 15);
    @(posedge clk); #1;

    // 2: back-to-back, six cycles apart
    base = log4.size();
    op4(7, 2);
    op4(10, 15);
    op4(15, 15);
    op4(0, 9);
    repeat (8) @(posedge clk);
    #1;
    check("t2_count", log4.size() - base, 4);
    if (log4.size() - base == 4) begin
      check("t2_p0", log4[base], 14);
      check("t2_p1", log4[base+1], 150);
      check("t2_p2", log4[base+2], 225);
      check("t2_p3", log4[base+3], 0);
      for (int i = 1; i < 4; i++) check("t2_spacing", logc4[base+i] - logc4[base+i-1], 6);
    end

    // 3: back-pressure
    ordy4 = 1'b0;
    op4(15, 15);
    n = 0;
    while (!ov4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) bound_fail("t3_out_valid");
    repeat (4) begin
      check("t3_hold_product", p4, 225);
      check("t3_hold_valid", ov4, 1);
      check("t3_hold_in_ready", ir4, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    ordy4 = 1'b1;
    @(negedge clk);
    check("t3_valid_before_edge", ov4, 1);
    @(negedge clk);
    check("t3_idle_in_ready", ir4, 1);
    check("t3_idle_out_valid", ov4, 0);
    @(posedge clk); #1;

    // 4: in_valid pulse during RUN is ignored
    base = log4.size();
    op4(5, 3);
    @(posedge clk); #1;
    a4 = 4'd3; b4 = 4'd3; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("t4_count", log4.size() - base, 1);
    if (log4.size() - base == 1) check("t4_product", log4[base], 15);

    // 5: async reset two steps into 10*15
    base = log4.size();
    op4(10, 15);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t5_out_valid", ov4, 0);
    check("t5_product", p4, 0);
    check("t5_in_ready", ir4, 1);
    check("t5_busy", busy4, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("t5_no_product", log4.size() - base, 0);

    // 6: exhaustive WIDTH=4, random WIDTH=8, both checked by the model every cycle
    base = log4.size();
    fork
      begin
        for (int x = 0; x < 16; x++)
          for (int y = 0; y < 16; y++) op4(x, y);
      end
      begin
        for (int i = 0; i < 1000; i++) op8($urandom_range(0, 255), $urandom_range(0, 255));
      end
    join
    repeat (14) @(posedge clk);
    #1;
    check("t6_count4", log4.size() - base, 256);
    check("t6_count8", log8_n, 1000);
    if (log4.size() > 0) check("t6_last4", log4[log4.size()-1], 225);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
